// File: rtl/tpu_pkg.sv
// ============================================================================
// Module   : tpu_pkg
// Purpose  : Shared widths and operand-store address map for the TPU datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tpu_pkg;

  localparam int DATA_W    = 8;
  localparam int N         = 2;
  localparam int ADDR_W    = 3;
  localparam int NUM_ELEMS = 2 * N * N;
  localparam int FEED_LAST = 5;

  // Row-major placement of A then B in the operand store
  localparam logic [ADDR_W-1:0] A00 = 3'd0;
  localparam logic [ADDR_W-1:0] A01 = 3'd1;
  localparam logic [ADDR_W-1:0] A10 = 3'd2;
  localparam logic [ADDR_W-1:0] A11 = 3'd3;
  localparam logic [ADDR_W-1:0] B00 = 3'd4;
  localparam logic [ADDR_W-1:0] B01 = 3'd5;
  localparam logic [ADDR_W-1:0] B10 = 3'd6;
  localparam logic [ADDR_W-1:0] B11 = 3'd7;

endpackage

`default_nettype wire

// File: rtl/operand_regfile.sv
// ============================================================================
// Module   : operand_regfile
// Purpose  : Eight operand registers with a loaded-mask, one write port and
//            parallel reads of every entry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_regfile
  import tpu_pkg::*;
#(
  parameter int DATA_W = tpu_pkg::DATA_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          mask_clr,
  output logic [NUM_ELEMS*DATA_W-1:0]   rd_data,
  output logic [NUM_ELEMS-1:0]          mask
);

  logic [DATA_W-1:0]    r_store [NUM_ELEMS];
  logic [NUM_ELEMS-1:0] r_mask;
  logic [NUM_ELEMS-1:0] w_mask_nxt;

  // Clear applies first so a same-cycle write still marks its own address
  always_comb begin
    w_mask_nxt = mask_clr ? '0 : r_mask;
    if (wr_en) begin
      w_mask_nxt[wr_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ELEMS; i++) begin
        r_store[i] <= '0;
      end
      r_mask <= '0;
    end else begin
      if (wr_en) begin
        r_store[wr_addr] <= wr_data;
      end
      r_mask <= w_mask_nxt;
    end
  end

  for (genvar g = 0; g < NUM_ELEMS; g++) begin : g_rd
    assign rd_data[g*DATA_W +: DATA_W] = r_store[g];
  end

  assign mask = r_mask;

endmodule

`default_nettype wire

// File: rtl/operand_buffer.sv
// ============================================================================
// Module   : operand_buffer
// Purpose  : Captures A/B operand bytes from the host and feeds them, skewed,
//            into the left and top edges of the 2x2 systolic MMU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_buffer
  import tpu_pkg::*;
#(
  parameter int DATA_W    = tpu_pkg::DATA_W,
  parameter int FEED_LAST = tpu_pkg::FEED_LAST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [2:0]        load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              feed_en,
  input  logic [2:0]        feed_cycle,
  output logic [DATA_W-1:0] a_row0,
  output logic [DATA_W-1:0] a_row1,
  output logic [DATA_W-1:0] b_col0,
  output logic [DATA_W-1:0] b_col1,
  output logic              feed_valid,
  output logic              mats_ready
);

  logic [NUM_ELEMS*DATA_W-1:0] w_rd_flat;
  logic [NUM_ELEMS-1:0]        w_mask;
  logic [DATA_W-1:0]           w_op [NUM_ELEMS];
  logic                        w_clr;
  logic [DATA_W-1:0]           w_a0, w_a1, w_b0, w_b1;

  assign w_clr = feed_en && (feed_cycle == 3'(FEED_LAST));

  operand_regfile #(
    .DATA_W (DATA_W)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (load_en),
    .wr_addr  (load_addr),
    .wr_data  (load_data),
    .mask_clr (w_clr),
    .rd_data  (w_rd_flat),
    .mask     (w_mask)
  );

  for (genvar g = 0; g < NUM_ELEMS; g++) begin : g_unpack
    assign w_op[g] = w_rd_flat[g*DATA_W +: DATA_W];
  end

  // Diagonal wavefront: row/column i enters the array i steps late
  always_comb begin
    w_a0 = '0;
    w_a1 = '0;
    w_b0 = '0;
    w_b1 = '0;
    if (feed_en) begin
      case (feed_cycle)
        3'd0: begin
          w_a0 = w_op[A00];
          w_b0 = w_op[B00];
        end
        3'd1: begin
          w_a0 = w_op[A01];
          w_a1 = w_op[A10];
          w_b0 = w_op[B10];
          w_b1 = w_op[B01];
        end
        3'd2: begin
          w_a1 = w_op[A11];
          w_b1 = w_op[B11];
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_row0     <= '0;
      a_row1     <= '0;
      b_col0     <= '0;
      b_col1     <= '0;
      feed_valid <= 1'b0;
      mats_ready <= 1'b0;
    end else begin
      a_row0     <= w_a0;
      a_row1     <= w_a1;
      b_col0     <= w_b0;
      b_col1     <= w_b1;
      feed_valid <= feed_en;
      mats_ready <= &w_mask;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_operand_buffer.sv
// ============================================================================
// Module   : tb_operand_buffer
// Purpose  : Scoreboard bench for operand_buffer load, skewed feed and mask.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_operand_buffer;

  logic       clk;
  logic       rst;
  logic       load_en;
  logic [2:0] load_addr;
  logic [7:0] load_data;
  logic       feed_en;
  logic [2:0] feed_cycle;
  logic [7:0] a_row0, a_row1, b_col0, b_col1;
  logic       feed_valid;
  logic       mats_ready;

  operand_buffer #(
    .DATA_W    (8),
    .FEED_LAST (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .feed_en    (feed_en),
    .feed_cycle (feed_cycle),
    .a_row0     (a_row0),
    .a_row1     (a_row1),
    .b_col0     (b_col0),
    .b_col1     (b_col1),
    .feed_valid (feed_valid),
    .mats_ready (mats_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] b0;
    logic [7:0] b1;
    logic       v;
  } exp_t;

  exp_t       q[$];
  logic [7:0] m_store [8];
  logic [7:0] m_mask;
  logic       m_ready;
  int         n_tests;
  int         n_fail;
  logic [7:0] nom_tab [6][4];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected registered outputs for one sampled (feed_en, feed_cycle)
  function automatic exp_t model_feed(input logic fe, input logic [2:0] k);
    exp_t e;
    e.a0 = 8'h00; e.a1 = 8'h00; e.b0 = 8'h00; e.b1 = 8'h00;
    e.v  = fe;
    if (fe) begin
      if (k == 3'd0) begin
        e.a0 = m_store[0]; e.b0 = m_store[4];
      end else if (k == 3'd1) begin
        e.a0 = m_store[1]; e.a1 = m_store[2];
        e.b0 = m_store[6]; e.b1 = m_store[5];
      end else if (k == 3'd2) begin
        e.a1 = m_store[3]; e.b1 = m_store[7];
      end
    end
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_store[i] = 8'h00;
    m_mask  = 8'h00;
    m_ready = 1'b0;
    q.delete();
  endtask

  // One clock: drive, predict, advance, compare against the scoreboard
  task automatic cyc(input logic le, input logic [2:0] la, input logic [7:0] ld,
                     input logic fe, input logic [2:0] fc);
    exp_t e;
    load_en    = le;
    load_addr  = la;
    load_data  = ld;
    feed_en    = fe;
    feed_cycle = fc;
    q.push_back(model_feed(fe, fc));
    @(posedge clk);
    m_ready = &m_mask;
    if (fe && fc == 3'd5) m_mask = 8'h00;
    if (le) begin
      m_store[la] = ld;
      m_mask[la]  = 1'b1;
    end
    #1;
    load_en = 1'b0;
    feed_en = 1'b0;
    if (q.size() == 0) begin
      chk("scoreboard_empty", 8'h01, 8'h00);
    end else begin
      e = q.pop_front();
      chk("a_row0", a_row0, e.a0);
      chk("a_row1", a_row1, e.a1);
      chk("b_col0", b_col0, e.b0);
      chk("b_col1", b_col1, e.b1);
      chk("feed_valid", 8'(feed_valid), 8'(e.v));
    end
    chk("mats_ready", 8'(mats_ready), 8'(m_ready));
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b1;
    load_en    = 1'b0;
    load_addr  = 3'd0;
    load_data  = 8'h00;
    feed_en    = 1'b0;
    feed_cycle = 3'd0;
    model_reset();
    nom_tab[0] = '{8'd1, 8'd0, 8'd5, 8'd0};
    nom_tab[1] = '{8'd2, 8'd3, 8'd7, 8'd6};
    nom_tab[2] = '{8'd0, 8'd4, 8'd0, 8'd8};
    nom_tab[3] = '{8'd0, 8'd0, 8'd0, 8'd0};
    nom_tab[4] = '{8'd0, 8'd0, 8'd0, 8'd0};
    nom_tab[5] = '{8'd0, 8'd0, 8'd0, 8'd0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_row0", a_row0, 8'h00);
    chk("rst_b_col0", b_col0, 8'h00);
    chk("rst_valid", 8'(feed_valid), 8'h00);
    chk("rst_ready", 8'(mats_ready), 8'h00);
    rst = 1'b0;

    // Partial load with a feed on the last write, then asynchronous reset
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 3'(i), 8'(8'h11 + i), (i == 3), 3'd0);
    chk("pre_rst_a_row0", a_row0, 8'h11);
    rst = 1'b1;
    #1;
    chk("async_rst_a_row0", a_row0, 8'h00);
    chk("async_rst_b_col0", b_col0, 8'h00);
    chk("async_rst_valid", 8'(feed_valid), 8'h00);
    chk("async_rst_mask", dut.u_regfile.r_mask, 8'h00);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Nominal load A=[[1,2],[3,4]] B=[[5,6],[7,8]]
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 3'(i), 8'(i + 1), 1'b0, 3'd0);
      chk("ready_during_load", 8'(mats_ready), 8'h00);
    end
    cyc(1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
    chk("ready_after_load", 8'(mats_ready), 8'h01);
    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, 3'd0, 8'h00, 1'b1, 3'(k));
      chk("nom_a_row0", a_row0, nom_tab[k][0]);
      chk("nom_a_row1", a_row1, nom_tab[k][1]);
      chk("nom_b_col0", b_col0, nom_tab[k][2]);
      chk("nom_b_col1", b_col1, nom_tab[k][3]);
      chk("nom_valid", 8'(feed_valid), 8'h01);
    end
    cyc(1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
    chk("ready_after_clear", 8'(mats_ready), 8'h00);

    // Reverse-order load
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 3'(7 - i), 8'(8'h80 + i), 1'b0, 3'd0);
    cyc(1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
    chk("ooo_ready", 8'(mats_ready), 8'h01);
    cyc(1'b0, 3'd0, 8'h00, 1'b1, 3'd0);
    chk("ooo_a_row0", a_row0, 8'h87);
    chk("ooo_b_col0", b_col0, 8'h83);

    // Feed disabled with a non-zero step index
    cyc(1'b0, 3'd0, 8'h00, 1'b0, 3'd1);
    chk("dis_a_row0", a_row0, 8'h00);
    chk("dis_a_row1", a_row1, 8'h00);
    chk("dis_b_col0", b_col0, 8'h00);
    chk("dis_b_col1", b_col1, 8'h00);
    chk("dis_valid", 8'(feed_valid), 8'h00);

    // Clear and load in the same cycle
    cyc(1'b1, 3'd2, 8'h55, 1'b1, 3'd5);
    chk("clr_load_mask", dut.u_regfile.r_mask, 8'h04);
    cyc(1'b0, 3'd0, 8'h00, 1'b1, 3'd1);
    chk("clr_load_a_row1", a_row1, 8'h55);
    chk("clr_load_ready", 8'(mats_ready), 8'h00);

    // Write during feed: old value this step, new value next step
    cyc(1'b1, 3'd1, 8'h99, 1'b1, 3'd1);
    chk("war_old_a01", a_row0, 8'h86);
    cyc(1'b0, 3'd0, 8'h00, 1'b1, 3'd1);
    chk("war_new_a01", a_row0, 8'h99);

    for (int i = 0; i < 60; i++)
      cyc(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
          1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/operand_buffer.md
Name: operand_buffer

Overview:
- Responder end of the weight-memory load interface driven by the TPU control unit.
- Captures 8 host bytes into an operand store: A matrix (2x2) at addresses 0-3, B matrix (2x2) at addresses 4-7, each row-major.
- During the feed phase, drives skewed operands into the 2x2 systolic MMU: A rows on the left edge, B columns on the top edge.
- Sits between the host byte input, the control unit, and the MMU.

Parameters:
- DATA_W, 8, operand width in bits.
- FEED_LAST, 5, feed_cycle value that ends a feed sequence and clears the loaded mask.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_en  in  1  write strobe from the control unit (wm_load_mat).
- load_addr  in  3  element address from the control unit (wm_addr); 0-3 = a00,a01,a10,a11; 4-7 = b00,b01,b10,b11.
- load_data  in  DATA_W  host byte, valid in the same cycle as load_en.
- feed_en  in  1  feed phase active (feeding_en).
- feed_cycle  in  3  feed step index (mmu_cycles).
- a_row0, a_row1  out  DATA_W each  left-edge operands for MMU rows 0 and 1.
- b_col0, b_col1  out  DATA_W each  top-edge operands for MMU columns 0 and 1.
- feed_valid  out  1  outputs carry a feed step.
- mats_ready  out  1  all 8 addresses written since the last clear.

Behaviour:
- Reset (async, rst=1):
  - All 8 stored operands = 0, loaded mask = 8'h00.
  - a_row0, a_row1, b_col0, b_col1, feed_valid, mats_ready = 0.
  - Reset mid-load or mid-feed aborts immediately. After release, mats_ready=0 until all 8 addresses are rewritten.
- Write:
  - When load_en=1, store[load_addr] <= load_data and mask[load_addr] <= 1 on the next edge.
  - Rewriting an address overwrites its value; the mask bit stays set.
  - Writes are not gated by feed_en.
- mats_ready: registered, equals &mask as of the previous edge. It rises the cycle after the 8th distinct address is written.
- Feed output timing:
  - All four operand outputs and feed_valid are registered.
  - Latency is 1 cycle from the (feed_en, feed_cycle) sample to the outputs.
- Skew schedule; the value k below is the sampled feed_cycle, and any slot not listed drives 0:
  - k=0: a_row0=a00, b_col0=b00.
  - k=1: a_row0=a01, a_row1=a10, b_col0=b10, b_col1=b01.
  - k=2: a_row1=a11, b_col1=b11.
  - k=3..7: all four operands = 0 (pipeline drain).
- feed_valid: next-cycle value = feed_en.
- feed_en=0: all operand outputs are 0 on the next cycle, regardless of feed_cycle.
- Read/write collision: reads use store contents before any same-cycle write (write-after-read). A write during feed is visible from the following feed step.
- Mask clear: when feed_en=1 and feed_cycle==FEED_LAST, mask <= 0. mats_ready drops 0 the cycle after the mask clears.
- Clear and load in the same cycle: the mask is cleared, then the written address bit is set, so the load wins for that bit only.
- Arithmetic: none. No saturation; pure selection and zero-fill.
- Out-of-order loads are legal; only mask coverage matters.

Decomposition:
- Shared package tpu_pkg holds:
  - DATA_W, N=2, ADDR_W=3.
  - Address constants A00..A11 = 0..3 and B00..B11 = 4..7.
  - FEED_LAST = 5.
- One sub-module, operand_regfile:
  - 8 x DATA_W registers plus the 8-bit loaded mask.
  - Async reset, single write port, eight parallel read outputs, mask-clear input.
- The top level holds the skew mux and the output registers.

Test Plan:
- Reset during activity: assert rst mid-load (after address 3) -> all outputs 0 immediately. After release, load 0-7 -> mats_ready=1 only after all eight writes.
- Nominal load and feed:
  - Load addresses 0..7 with data 1..8 (A=[[1,2],[3,4]], B=[[5,6],[7,8]]); mats_ready=1 the cycle after the addr-7 write.
  - Feed k=0..5, checked one cycle later:
    - k0: rows (1,0), cols (5,0).
    - k1: rows (2,3), cols (7,6).
    - k2: rows (0,4), cols (0,8).
    - k3-k5: all 0.
  - feed_valid=1 throughout; mats_ready=0 after the k=5 step.
- Out-of-order load: load 7,6,...,0 with data 0x80..0x87 -> mats_ready asserts after the 8th write. k=0 then yields a_row0=0x87, b_col0=0x83.
- Feed disabled: feed_en=0 with feed_cycle=1 and full store -> all operand outputs and feed_valid stay 0.
- Clear and load in the same cycle: load addr 2 with 0x55 while feed_en=1 and feed_cycle=5 -> mask == 8'h04, mats_ready=0. A following k=1 step shows a_row1=0x55.
- Write during feed: write addr 1 = 0x99 on the same cycle as k=1 -> that step outputs the old a01. Repeating k=1 next cycle outputs a_row0=0x99.
